npu_int32_alu: RTL and testbench

NPU_INT32_ALU -- requirements
Module: npu_int32_alu

---
 rtl/npu_int32_alu.sv | 123 ++++++++++++
 tb/tb_npu_int32_alu.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/npu_int32_alu.sv
// Single-issue 32-bit integer ALU with valid/ready handshakes on both sides.
// MUL is a 32-step iterative shift-add; every other op completes in one cycle.
module npu_int32_alu (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  int32_opc,
  input  logic [31:0] int32_a,
  input  logic [31:0] int32_b,
  input  logic        int32_iv,
  output logic        int32_ir,
  output logic [31:0] int32_y,
  output logic        int32_ov,
  input  logic        int32_or
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SLL = 3'd6,
    OP_SRA = 3'd7
  } opc_t;

  state_t      r_state;
  logic [31:0] r_y;
  logic        r_ov;
  logic [31:0] r_acc;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [4:0]  r_cnt;

  logic        w_accept;
  logic [31:0] w_single;
  logic [31:0] w_acc_next;

  // Ready is a pure state decode so the upstream sees no combinational path.
  assign int32_ir = (r_state == S_IDLE);
  assign w_accept = int32_iv && int32_ir;
  assign int32_y  = r_y;
  assign int32_ov = r_ov;

  // NOTE: default first so every path assigns w_single and no latch is inferred.
  always_comb begin
    w_single = '0;
    case (opc_t'(int32_opc))
      OP_ADD:  w_single = int32_a + int32_b;
      OP_SUB:  w_single = int32_a - int32_b;
      OP_AND:  w_single = int32_a & int32_b;
      OP_OR:   w_single = int32_a | int32_b;
      OP_XOR:  w_single = int32_a ^ int32_b;
      OP_SLL:  w_single = int32_a << int32_b[4:0];
      OP_SRA:  w_single = $unsigned($signed(int32_a) >>> int32_b[4:0]);
      default: w_single = '0;
    endcase
  end

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : 32'd0);

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_y      <= '0;
      r_ov     <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (opc_t'(int32_opc) == OP_MUL) begin
              r_state  <= S_MUL;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_mcand  <= int32_a;
              r_mplier <= int32_b;
            end else begin
              r_state <= S_DONE;
              r_y     <= w_single;
              r_ov    <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= S_DONE;
            r_y     <= w_acc_next;
            r_ov    <= 1'b1;
          end
        end
        S_DONE: begin
          // Result stays put under back-pressure; cleared on the handshake edge.
          if (int32_or) begin
            r_state <= S_IDLE;
            r_y     <= '0;
            r_ov    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_y     <= '0;
          r_ov    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npu_int32_alu.sv
// Directed bench for npu_int32_alu: reset, single-cycle ops, iterative MUL,
// back-pressure, reset abort and back-to-back command streaming.
module tb_npu_int32_alu;

  logic        clock;
  logic        reset;
  logic [2:0]  int32_opc;
  logic [31:0] int32_a;
  logic [31:0] int32_b;
  logic        int32_iv;
  logic        int32_ir;
  logic [31:0] int32_y;
  logic        int32_ov;
  logic        int32_or;

  int checks = 0;
  int errors = 0;

  npu_int32_alu dut (
    .clock     (clock),
    .reset     (reset),
    .int32_opc (int32_opc),
    .int32_a   (int32_a),
    .int32_b   (int32_b),
    .int32_iv  (int32_iv),
    .int32_ir  (int32_ir),
    .int32_y   (int32_y),
    .int32_ov  (int32_ov),
    .int32_or  (int32_or)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present a command for exactly one edge; returns just after the acceptance edge.
  task automatic issue(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b);
    int32_opc = opc;
    int32_a   = a;
    int32_b   = b;
    int32_iv  = 1'b1;
    check("issue_ready", {31'd0, int32_ir}, 32'd1);
    step();
    int32_iv  = 1'b0;
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] opc, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (opc)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return p[31:0];
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a ^ b;
      3'd6:    return a << b[4:0];
      default: return $unsigned($signed(a) >>> b[4:0]);
    endcase
  endfunction

  logic [2:0]  q_opc [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [31:0] q_a   [8] = '{32'h7FFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hF0F0F0F0,
                             32'hF0F0F0F0, 32'hAAAAAAAA, 32'h00000001, 32'h7FFFFFF0};
  logic [31:0] q_b   [8] = '{32'h00000001, 32'h00000001, 32'hFFFFFFFF, 32'h3C3C3C3C,
                             32'h0F0F0000, 32'hFFFF0000, 32'h0000003F, 32'h00000021};
  logic [31:0] q_exp [8] = '{32'h80000000, 32'hFFFFFFFF, 32'h00000001, 32'h30303030,
                             32'hFFFFF0F0, 32'h5555AAAA, 32'h80000000, 32'h3FFFFFF8};

  initial begin
    reset     = 1'b0;
    int32_iv  = 1'b1;
    int32_opc = 3'd0;
    int32_a   = 32'd1;
    int32_b   = 32'd1;
    int32_or  = 1'b1;

    // Reset with a valid command pending: nothing may be accepted.
    step();
    step();
    check("rst_ir", {31'd0, int32_ir}, 32'd1);
    check("rst_ov", {31'd0, int32_ov}, 32'd0);
    check("rst_y", int32_y, 32'd0);
    int32_iv = 1'b0;
    reset    = 1'b1;
    step();
    check("post_rst_ov", {31'd0, int32_ov}, 32'd0);

    // ADD wrap, latency 1, ready returns after handshake.
    issue(3'd0, 32'hFFFFFFFF, 32'h00000002);
    check("add_ov", {31'd0, int32_ov}, 32'd1);
    check("add_y", int32_y, 32'h00000001);
    check("add_ir_busy", {31'd0, int32_ir}, 32'd0);
    step();
    check("add_ir_back", {31'd0, int32_ir}, 32'd1);
    check("add_ov_clr", {31'd0, int32_ov}, 32'd0);
    check("add_y_clr", int32_y, 32'd0);

    // MUL: 32 edges from acceptance to valid.
    begin
      int  n;
      bit  ir_low_ok;
      issue(3'd2, 32'h00010003, 32'h00020005);
      n = 0;
      ir_low_ok = 1'b1;
      while (!int32_ov && n < 40) begin
        if (int32_ir) ir_low_ok = 1'b0;
        step();
        n++;
      end
      check("mul_latency", n, 32'd32);
      check("mul_ir_low", {31'd0, ir_low_ok}, 32'd1);
      check("mul_y", int32_y, 32'h000B000F);
      step();
      check("mul_ov_clr", {31'd0, int32_ov}, 32'd0);
    end

    // Shifts: b[4:0] = 4, upper bits of b ignored.
    issue(3'd7, 32'h80000000, 32'h00000024);
    check("sra_y", int32_y, 32'hF8000000);
    step();
    issue(3'd6, 32'h80000000, 32'h00000024);
    check("sll_ov", {31'd0, int32_ov}, 32'd1);
    check("sll_y", int32_y, 32'h00000000);
    step();

    // Back-pressure: result held while downstream stalls, iv pulses ignored.
    int32_or = 1'b0;
    issue(3'd1, 32'd5, 32'd7);
    for (int k = 0; k < 10; k++) begin
      int32_iv  = k[0];
      int32_opc = 3'd0;
      int32_a   = k;
      int32_b   = 32'd100;
      check("bp_ov", {31'd0, int32_ov}, 32'd1);
      check("bp_y", int32_y, 32'hFFFFFFFE);
      check("bp_ir", {31'd0, int32_ir}, 32'd0);
      step();
    end
    int32_iv = 1'b0;
    int32_or = 1'b1;
    check("bp_y_final", int32_y, 32'hFFFFFFFE);
    step();
    check("bp_hs_ov", {31'd0, int32_ov}, 32'd0);
    check("bp_hs_y", int32_y, 32'd0);
    check("bp_hs_ir", {31'd0, int32_ir}, 32'd1);

    // Reset at edge 10 after a MUL acceptance aborts it for good.
    begin
      bit ov_seen;
      issue(3'd2, 32'd3, 32'd5);
      for (int k = 1; k < 10; k++) step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      check("abort_ov", {31'd0, int32_ov}, 32'd0);
      check("abort_y", int32_y, 32'd0);
      check("abort_ir", {31'd0, int32_ir}, 32'd1);
      ov_seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
        if (int32_ov) ov_seen = 1'b1;
        step();
      end
      check("abort_no_result", {31'd0, ov_seen}, 32'd0);
      issue(3'd0, 32'd1, 32'd1);
      check("abort_next_ov", {31'd0, int32_ov}, 32'd1);
      check("abort_next_y", int32_y, 32'd2);
      step();
    end

    // Back-to-back: iv held high, one acceptance per result, bubble between results.
    begin
      int  idx;
      int  res;
      int  cyc;
      bit  prev_ov;
      bit  bubble_ok;
      bit  acc_now;
      idx = 0;
      res = 0;
      cyc = 0;
      prev_ov = 1'b0;
      bubble_ok = 1'b1;
      int32_opc = q_opc[0];
      int32_a   = q_a[0];
      int32_b   = q_b[0];
      int32_iv  = 1'b1;
      while (res < 8 && cyc < 400) begin
        if (int32_ov) begin
          if (prev_ov) bubble_ok = 1'b0;
          if (res < 8) begin
            check($sformatf("b2b_tab_%0d", res), int32_y, q_exp[res]);
            check($sformatf("b2b_ref_%0d", res), int32_y, ref_alu(q_opc[res], q_a[res], q_b[res]));
          end
          res++;
        end
        prev_ov = int32_ov;
        acc_now = int32_ir && int32_iv;
        step();
        cyc++;
        if (acc_now) begin
          idx++;
          if (idx < 8) begin
            int32_opc = q_opc[idx];
            int32_a   = q_a[idx];
            int32_b   = q_b[idx];
          end else begin
            int32_iv = 1'b0;
          end
        end
      end
      int32_iv = 1'b0;
      check("b2b_results", res, 32'd8);
      check("b2b_accepts", idx, 32'd8);
      check("b2b_bubble", {31'd0, bubble_ok}, 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
